fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_unit_if.sv | 24 ++
 rtl/program_counter.sv | 35 +++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths, encodings and the fetch-state enum.
package cpu_pkg;

  localparam int PC_W    = 26;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DROP,
    ISSUE
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/program_counter.sv
// Program counter register: flush beats load beats increment; increment wraps silently.
module program_counter
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_en,
  input  logic [PC_W-1:0] flush_pc,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d, pc_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d = pc_q;
    if (flush_en)     pc_d = flush_pc;
    else if (load_en) pc_d = load_val;
    else if (inc_en)  pc_d = pc_q + PC_W'(1);
  end

  // NOTE: state flops use non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues imem requests, drops redirected responses, presents one instruction.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 26'h0000000
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               load_pc,
  input  logic [PC_W-1:0]    load_pc_val,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc
);

  fetch_state_e       state_d, state_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [PC_W-1:0]    drop_addr_d, drop_addr_q;
  logic               pc_flush, pc_load, pc_inc;

  program_counter #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_en (pc_flush),
    .flush_pc (flush_pc),
    .load_en  (pc_load),
    .load_val (load_pc_val),
    .inc_en   (pc_inc),
    .pc       (pc)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    drop_addr_d = drop_addr_q;
    pc_flush    = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;

    unique case (state_q)
      IDLE: begin
        pc_flush = flush;
        state_d  = FETCH;
      end
      FETCH: begin
        if (flush) begin
          pc_flush = 1'b1;
          // Without ack the old request is still on the bus and must be drained.
          if (!imem.imem_ack) begin
            drop_addr_d = pc;
            state_d     = DROP;
          end
        end else if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = ISSUE;
        end
      end
      DROP: begin
        pc_flush = flush;
        if (imem.imem_ack) state_d = FETCH;
      end
      ISSUE: begin
        if (flush) begin
          pc_flush = 1'b1;
          state_d  = FETCH;
        end else if (!stall) begin
          pc_load = load_pc;
          pc_inc  = !load_pc;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_q     <= NOP;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  assign imem.imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem.imem_addr = (state_q == DROP) ? drop_addr_q : pc;
  assign instr_valid    = (state_q == ISSUE);
  // The control unit must never see a stale word while nothing valid is held.
  assign instruction    = instr_valid ? instr_q : NOP;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic vs a behavioural model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [PC_W-1:0] RST_PC  = 26'h0000000;
  localparam logic [PC_W-1:0] PC_MASK = 26'h3FFFFFF;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               stall = 1'b0;
  logic               load_pc = 1'b0;
  logic [PC_W-1:0]    load_pc_val = '0;
  logic               flush = 1'b0;
  logic [PC_W-1:0]    flush_pc = '0;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;

  int n_checks = 0;
  int n_errors = 0;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus),
    .stall       (stall),
    .load_pc     (load_pc),
    .load_pc_val (load_pc_val),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // Behavioural model: tracks what the unit is doing as plain flags and values.
  bit                 m_started;
  bit                 m_have_instr;
  bit                 m_abandoning;
  logic [PC_W-1:0]    m_pc;
  logic [PC_W-1:0]    m_abandon_addr;
  logic [INSTR_W-1:0] m_instr;

  task automatic model_reset();
    m_started      = 0;
    m_have_instr   = 0;
    m_abandoning   = 0;
    m_pc           = RST_PC;
    m_abandon_addr = RST_PC;
    m_instr        = '0;
  endtask

  task automatic model_step();
    if (!m_started) begin
      m_started = 1;
      if (flush) m_pc = flush_pc;
    end else if (m_have_instr) begin
      if (flush) begin
        m_pc = flush_pc;
        m_have_instr = 0;
      end else if (!stall) begin
        m_pc = load_pc ? load_pc_val : PC_W'((32'(m_pc) + 1) & 32'(PC_MASK));
        m_have_instr = 0;
      end
    end else if (m_abandoning) begin
      if (flush) m_pc = flush_pc;
      if (imem_bus.imem_ack) m_abandoning = 0;
    end else begin
      if (flush) begin
        if (!imem_bus.imem_ack) begin
          m_abandoning   = 1;
          m_abandon_addr = m_pc;
        end
        m_pc = flush_pc;
      end else if (imem_bus.imem_ack) begin
        m_instr      = imem_bus.imem_rdata;
        m_have_instr = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".req"},   32'(imem_bus.imem_req), 32'(m_started && !m_have_instr));
    check({tag, ".addr"},  32'(imem_bus.imem_addr), 32'(m_abandoning ? m_abandon_addr : m_pc));
    check({tag, ".valid"}, 32'(instr_valid), 32'(m_have_instr));
    check({tag, ".instr"}, instruction, m_have_instr ? m_instr : 32'h0);
    check({tag, ".pc"},    32'(pc), 32'(m_pc));
  endtask

  task automatic drive(input logic fl, input logic [PC_W-1:0] fpc, input logic ld,
                       input logic [PC_W-1:0] lval, input logic st, input logic ack,
                       input logic [INSTR_W-1:0] rdata);
    flush                = fl;
    flush_pc             = fpc;
    load_pc              = ld;
    load_pc_val          = lval;
    stall                = st;
    imem_bus.imem_ack    = ack;
    imem_bus.imem_rdata  = rdata;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    drive(0, '0, 0, '0, 0, 0, '0);
    model_reset();

    // Reset values held while rst_n is low, across a clock edge.
    @(negedge clk);
    check_all("reset");
    check("reset.addr_const", 32'(imem_bus.imem_addr), 32'(RST_PC));
    rst_n = 1'b1;

    // First fetch, ack on the second FETCH cycle.
    cycle("idle_to_fetch");
    cycle("fetch_wait");
    drive(0, '0, 0, '0, 0, 1, 32'h04221800);
    cycle("fetch_ack");
    check("first.valid", 32'(instr_valid), 32'h1);
    check("first.pc", 32'(pc), 32'h0);
    check("first.instr", instruction, 32'h04221800);
    drive(0, '0, 0, '0, 0, 0, '0);
    cycle("seq_next");
    check("seq.addr", 32'(imem_bus.imem_addr), 32'h1);

    // Branch taken from ISSUE.
    drive(0, '0, 0, '0, 0, 1, 32'hA5A50001);
    cycle("br_fetch");
    drive(0, '0, 1, 26'h000040, 0, 0, '0);
    cycle("br_take");
    check("branch.addr", 32'(imem_bus.imem_addr), 32'h40);

    // Stall in ISSUE with a pending branch; ack/load ignored while held.
    drive(0, '0, 1, 26'h000011, 0, 1, 32'h0BADF00D);
    cycle("load_in_fetch_ignored");
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 26'h000080, 1, 1, 32'hDEADBEEF);
      cycle("stall_hold");
      check("stall.req", 32'(imem_bus.imem_req), 32'h0);
      check("stall.instr", instruction, 32'h0BADF00D);
      check("stall.pc", 32'(pc), 32'h40);
    end
    drive(0, '0, 1, 26'h000080, 0, 0, '0);
    cycle("stall_release");
    check("stall.branch_addr", 32'(imem_bus.imem_addr), 32'h80);

    // Flush before ack: abandoned request drained, then refetch at flush target.
    drive(1, 26'h000100, 0, '0, 0, 0, '0);
    cycle("flush_to_drop");
    check("drop.addr_held", 32'(imem_bus.imem_addr), 32'h80);
    check("drop.req", 32'(imem_bus.imem_req), 32'h1);
    drive(0, '0, 0, '0, 0, 0, '0);
    cycle("drop_wait");
    drive(0, '0, 0, '0, 0, 1, 32'hFFFFFFFF);
    cycle("drop_ack");
    check("drop.dropped_valid", 32'(instr_valid), 32'h0);
    check("drop.next_addr", 32'(imem_bus.imem_addr), 32'h100);

    // Flush and ack together: no drain, new request goes out at once.
    drive(1, 26'h000200, 0, '0, 0, 1, 32'hFFFFFFFF);
    cycle("flush_ack_same");
    check("flush_ack.addr", 32'(imem_bus.imem_addr), 32'h200);
    drive(0, '0, 0, '0, 0, 1, 32'h12345678);
    cycle("after_flush_ack");
    check("flush_ack.instr", instruction, 32'h12345678);

    // PC wrap at the top of the address space.
    drive(0, '0, 1, 26'h3FFFFFF, 0, 0, '0);
    cycle("to_top");
    drive(0, '0, 0, '0, 0, 1, 32'h00000013);
    cycle("top_fetch");
    check("wrap.pc_top", 32'(pc), 32'h3FFFFFF);
    drive(0, '0, 0, '0, 0, 0, '0);
    cycle("wrap");
    check("wrap.addr", 32'(imem_bus.imem_addr), 32'h0);

    // Async reset in the middle of DROP, no clock edge needed.
    drive(1, 26'h000300, 0, '0, 0, 0, '0);
    cycle("flush_to_drop2");
    drive(0, '0, 0, '0, 0, 0, '0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model, with occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      logic [PC_W-1:0] lv;
      lv = ($urandom_range(0, 7) == 0) ? 26'h3FFFFFF : PC_W'($urandom);
      drive($urandom_range(0, 9) == 0, PC_W'($urandom),
            $urandom_range(0, 2) == 0, lv,
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) < 2, 32'($urandom));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rand_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        cycle("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
